// File: rtl/lsu_unit.sv
// Load/store unit: accepts one EX-stage memory request at a time, drives the data bus,
// formats the load response into a register-file writeback, and aborts on bus timeout.
module lsu_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [4:0]  req_rd_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_be_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    output logic        wb_we_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        busy_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WB} state_e;

    state_e           state_q;
    logic             we_q;
    logic [2:0]       funct3_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [4:0]       rd_q;
    logic [31:0]      rdata_q;
    logic [CNT_W-1:0] cnt_q;
    logic             misalign_q;
    logic             bus_err_q;

    logic             req_bad;
    logic [3:0]       bus_be;
    logic [31:0]      bus_wdata;
    logic [31:0]      rdata_shift;
    logic [31:0]      rdata_d;
    logic             timeout;

    // Reserved encodings are rejected alongside misaligned addresses; stores have no BU/HU.
    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        req_bad = 1'b1;
        case (req_funct3_i)
            3'b000:  req_bad = 1'b0;
            3'b001:  req_bad = req_addr_i[0];
            3'b010:  req_bad = |req_addr_i[1:0];
            3'b100:  req_bad = req_we_i;
            3'b101:  req_bad = req_we_i | req_addr_i[0];
            default: req_bad = 1'b1;
        endcase
    end

    always_comb begin
        bus_be      = 4'b1111;
        bus_wdata   = wdata_q;
        rdata_shift = bus_rdata_i >> {addr_q[1:0], 3'b000};
        rdata_d     = bus_rdata_i;
        case (funct3_q[1:0])
            2'b00: begin
                bus_be    = 4'b0001 << addr_q[1:0];
                bus_wdata = {4{wdata_q[7:0]}};
                rdata_d   = {{24{~funct3_q[2] & rdata_shift[7]}}, rdata_shift[7:0]};
            end
            2'b01: begin
                bus_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                bus_wdata = {2{wdata_q[15:0]}};
                rdata_d   = {{16{~funct3_q[2] & rdata_shift[15]}}, rdata_shift[15:0]};
            end
            default: ;
        endcase
    end

    // Saturating compare: a grant on the last REQ cycle must still time out in WAIT.
    assign timeout = (cnt_q >= CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            funct3_q   <= 3'b000;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            rd_q       <= 5'd0;
            rdata_q    <= 32'h0;
            cnt_q      <= '0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        we_q     <= req_we_i;
                        funct3_q <= req_funct3_i;
                        addr_q   <= req_addr_i;
                        wdata_q  <= req_wdata_i;
                        rd_q     <= req_rd_i;
                        cnt_q    <= '0;
                        if (req_bad) misalign_q <= 1'b1;
                        else         state_q    <= S_REQ;
                    end
                end
                S_REQ: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (bus_gnt_i) begin
                        state_q <= S_WAIT;
                    end else if (timeout) begin
                        state_q   <= S_IDLE;
                        bus_err_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (bus_rvalid_i) begin
                        if (we_q) begin
                            state_q <= S_IDLE;
                        end else begin
                            rdata_q <= rdata_d;
                            state_q <= S_WB;
                        end
                    end else if (timeout) begin
                        state_q   <= S_IDLE;
                        bus_err_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Outputs decode straight from registers, so reset clears them without waiting for a clock.
    assign req_ready_o = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign bus_req_o   = (state_q == S_REQ);
    assign bus_we_o    = bus_req_o & we_q;
    assign bus_addr_o  = bus_req_o ? {addr_q[31:2], 2'b00} : 32'h0;
    assign bus_be_o    = bus_req_o ? bus_be : 4'b0000;
    assign bus_wdata_o = bus_we_o ? bus_wdata : 32'h0;
    assign wb_we_o     = (state_q == S_WB) && (rd_q != 5'd0);
    assign wb_rd_o     = (state_q == S_WB) ? rd_q : 5'd0;
    assign wb_data_o   = (state_q == S_WB) ? rdata_q : 32'h0;
    assign misalign_o  = misalign_q;
    assign bus_err_o   = bus_err_q;

endmodule

// File: tb/tb_lsu_unit.sv
// Randomized bench for lsu_unit, checked against a byte-arithmetic reference model.
module tb_lsu_unit;

    localparam int TO = 20;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i, req_ready_o, req_we_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic [4:0]  req_rd_i;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_gnt_i, bus_rvalid_i;
    logic [31:0] bus_rdata_i;
    logic        wb_we_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        busy_o, misalign_o, bus_err_o;

    int n_vec = 0;
    int n_err = 0;

    lsu_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .req_rd_i(req_rd_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
        .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
        .wb_we_o(wb_we_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
        .busy_o(busy_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit model_bad(input bit we, input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        if (!legal) return 1'b1;
        return (a % size_of(f3)) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int s = size_of(f3);
        int off = int'(a % 4);
        return 4'(((1 << s) - 1) << off);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (size_of(f3))
            1:       return (d & 32'hFF) * 32'h0101_0101;
            2:       return (d & 32'hFFFF) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] r);
        logic [31:0] v;
        v = r >> (8 * (a % 4));
        case (size_of(f3))
            1: begin
                v = v & 32'hFF;
                if (!f3[2] && v >= 32'd128) v = v - 32'd256;
            end
            2: begin
                v = v & 32'hFFFF;
                if (!f3[2] && v >= 32'd32768) v = v - 32'd65536;
            end
            default: v = r;
        endcase
        return v;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // One complete transaction; gnt_dly/rv_dly are wait cycles before grant/response.
    task automatic run_txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rd, input int gnt_dly,
                           input int rv_dly, input logic [31:0] rdata, input bit hold_in_wb);
        logic [38:0] exp_bus;
        logic [39:0] exp_wb;
        logic [31:0] exp_wd;
        n_vec++;
        if (req_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL ready_before_accept: got %b expected 1", req_ready_o);
        end
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
        req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3;
        req_addr_i = addr; req_wdata_i = wdata; req_rd_i = rd;
        step();
        req_valid_i = 1'b0; req_we_i = $urandom; req_funct3_i = 3'($urandom);
        req_addr_i = $urandom; req_wdata_i = $urandom; req_rd_i = 5'($urandom);
        if (model_bad(we, f3, addr)) begin
            n_vec++;
            if ({misalign_o, bus_req_o, req_ready_o, busy_o} !== 4'b1010) begin
                n_err++;
                $display("FAIL misalign_pulse: got %b expected 1010 (misalign,bus_req,ready,busy)",
                         {misalign_o, bus_req_o, req_ready_o, busy_o});
            end
            step();
            n_vec++;
            if ({misalign_o, bus_req_o, req_ready_o} !== 3'b001) begin
                n_err++;
                $display("FAIL misalign_end: got %b expected 001", {misalign_o, bus_req_o, req_ready_o});
            end
            return;
        end
        n_vec++;
        if (misalign_o !== 1'b0) begin
            n_err++;
            $display("FAIL misalign_spurious: got %b expected 0 (f3=%b addr=%h)", misalign_o, f3, addr);
        end
        exp_wd  = we ? model_wdata(f3, wdata) : 32'h0;
        exp_bus = {1'b1, we, addr & ~32'd3, model_be(f3, addr), 1'b1};
        for (int i = 0; i <= gnt_dly; i++) begin
            n_vec++;
            if ({bus_req_o, bus_we_o, bus_addr_o, bus_be_o, busy_o} !== exp_bus || bus_wdata_o !== exp_wd
                || req_ready_o !== 1'b0) begin
                n_err++;
                $display("FAIL bus_request: got req/we/addr/be/busy=%h wdata=%h ready=%b expected %h wdata=%h ready=0",
                         {bus_req_o, bus_we_o, bus_addr_o, bus_be_o, busy_o}, bus_wdata_o, req_ready_o,
                         exp_bus, exp_wd);
            end
            bus_gnt_i = (i == gnt_dly);
            bus_rvalid_i = $urandom;
            bus_rdata_i = $urandom;
            step();
        end
        bus_gnt_i = 1'b0;
        for (int i = 0; i <= rv_dly; i++) begin
            n_vec++;
            if ({bus_req_o, busy_o, wb_we_o, bus_err_o} !== 4'b0100) begin
                n_err++;
                $display("FAIL wait_state: got %b expected 0100 (bus_req,busy,wb_we,err)",
                         {bus_req_o, busy_o, wb_we_o, bus_err_o});
            end
            bus_rvalid_i = (i == rv_dly);
            bus_rdata_i = (i == rv_dly) ? rdata : $urandom;
            step();
        end
        bus_rvalid_i = 1'b0;
        if (!we) begin
            exp_wb = {rd != 5'd0, rd, model_load(f3, addr, rdata), 1'b1, 1'b0};
            n_vec++;
            if ({wb_we_o, wb_rd_o, wb_data_o, busy_o, req_ready_o} !== exp_wb) begin
                n_err++;
                $display("FAIL writeback: got we/rd/data/busy/ready=%h expected %h (f3=%b addr=%h rdata=%h)",
                         {wb_we_o, wb_rd_o, wb_data_o, busy_o, req_ready_o}, exp_wb, f3, addr, rdata);
            end
            if (hold_in_wb) begin
                req_valid_i = 1'b1; req_we_i = 1'b1; req_funct3_i = 3'b010;
                req_addr_i = $urandom & ~32'd3;
            end
            step();
            req_valid_i = 1'b0;
        end
        n_vec++;
        if ({wb_we_o, busy_o, req_ready_o, bus_req_o, bus_err_o} !== 5'b00100) begin
            n_err++;
            $display("FAIL back_to_idle: got %b expected 00100 (wb_we,busy,ready,bus_req,err)",
                     {wb_we_o, busy_o, req_ready_o, bus_req_o, bus_err_o});
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_i = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_funct3_i = 3'b0;
        req_addr_i = 32'h0; req_wdata_i = 32'h0; req_rd_i = 5'd0;
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0;
        #13;
        n_vec++;
        if ({req_ready_o, busy_o, bus_req_o, bus_we_o, misalign_o, bus_err_o, wb_we_o, bus_be_o, wb_rd_o}
            !== {1'b1, 15'b0}) begin
            n_err++;
            $display("FAIL reset_ctrl: got %h expected %h",
                     {req_ready_o, busy_o, bus_req_o, bus_we_o, misalign_o, bus_err_o, wb_we_o, bus_be_o, wb_rd_o},
                     {1'b1, 15'b0});
        end
        n_vec++;
        if ({bus_addr_o, bus_wdata_o, wb_data_o} !== 96'h0) begin
            n_err++;
            $display("FAIL reset_data: got %h expected 0", {bus_addr_o, bus_wdata_o, wb_data_o});
        end
        @(negedge clk_i);
        rst_i = 1'b1;
        step();
    endtask

    task automatic test_directed();
        run_txn(1'b0, 3'b000, 32'h0000_1003, 32'h0, 5'd5, 0, 0, 32'h80FF_0000, 1'b0);
        run_txn(1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 5'd0, 0, 0, 32'h0, 1'b0);
        run_txn(1'b0, 3'b010, 32'h0000_3001, 32'h0, 5'd1, 0, 0, 32'h0, 1'b0);
        run_txn(1'b0, 3'b101, 32'h0000_4002, 32'h0, 5'd0, 0, 0, 32'h9234_0000, 1'b0);
    endtask

    task automatic test_random(input int n);
        for (int t = 0; t < n; t++) begin
            int gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                bus_gnt_i = $urandom; bus_rvalid_i = $urandom; bus_rdata_i = $urandom;
                step();
                n_vec++;
                if ({busy_o, bus_req_o, wb_we_o} !== 3'b000) begin
                    n_err++;
                    $display("FAIL idle_ignores_bus: got %b expected 000", {busy_o, bus_req_o, wb_we_o});
                end
            end
            run_txn($urandom, 3'($urandom), $urandom, $urandom, 5'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom, $urandom);
        end
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 6; t++)
            run_txn(1'b0, 3'b010, $urandom & ~32'd3, 32'h0, 5'($urandom_range(1, 31)), 0, 0, $urandom, 1'b1);
    endtask

    task automatic start_load(input logic [31:0] addr, input logic [4:0] rd);
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
        req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'b010;
        req_addr_i = addr; req_rd_i = rd;
        step();
        req_valid_i = 1'b0;
    endtask

    task automatic test_timeout_req();
        start_load(32'h0000_5000, 5'd7);
        for (int i = 0; i < TO; i++) begin
            n_vec++;
            if ({bus_req_o, bus_err_o} !== 2'b10) begin
                n_err++;
                $display("FAIL timeout_req_hold[%0d]: got %b expected 10 (bus_req,err)", i, {bus_req_o, bus_err_o});
            end
            step();
        end
        n_vec++;
        if ({bus_err_o, bus_req_o, req_ready_o, wb_we_o} !== 4'b1010) begin
            n_err++;
            $display("FAIL timeout_req_abort: got %b expected 1010 (err,bus_req,ready,wb_we)",
                     {bus_err_o, bus_req_o, req_ready_o, wb_we_o});
        end
        step();
        n_vec++;
        if ({bus_err_o, wb_we_o, busy_o} !== 3'b000) begin
            n_err++;
            $display("FAIL timeout_req_after: got %b expected 000", {bus_err_o, wb_we_o, busy_o});
        end
    endtask

    // Grant at once, then the response arrives (or not) on the last allowed cycle.
    task automatic test_timeout_wait(input bit respond);
        logic [31:0] rdata;
        rdata = $urandom;
        start_load(32'h0000_6000, 5'd9);
        bus_gnt_i = 1'b1;
        step();
        bus_gnt_i = 1'b0;
        for (int i = 0; i < TO - 1; i++) begin
            n_vec++;
            if ({busy_o, bus_err_o, wb_we_o} !== 3'b100) begin
                n_err++;
                $display("FAIL timeout_wait_hold[%0d]: got %b expected 100", i, {busy_o, bus_err_o, wb_we_o});
            end
            bus_rvalid_i = respond && (i == TO - 2);
            bus_rdata_i = rdata;
            step();
        end
        bus_rvalid_i = 1'b0;
        n_vec++;
        if (respond) begin
            if ({bus_err_o, wb_we_o, wb_data_o} !== {2'b01, rdata}) begin
                n_err++;
                $display("FAIL response_wins: got %h expected %h", {bus_err_o, wb_we_o, wb_data_o}, {2'b01, rdata});
            end
        end else if ({bus_err_o, busy_o, wb_we_o} !== 3'b100) begin
            n_err++;
            $display("FAIL timeout_wait_abort: got %b expected 100", {bus_err_o, busy_o, wb_we_o});
        end
        step();
    endtask

    task automatic test_reset_mid(input bit in_wait);
        start_load(32'h0000_7000, 5'd3);
        if (in_wait) begin
            bus_gnt_i = 1'b1;
            step();
            bus_gnt_i = 1'b0;
        end
        #2 rst_i = 1'b0;
        #1;
        n_vec++;
        if ({busy_o, bus_req_o, req_ready_o, wb_we_o} !== 4'b0010) begin
            n_err++;
            $display("FAIL reset_async_drop: got %b expected 0010 (busy,bus_req,ready,wb_we)",
                     {busy_o, bus_req_o, req_ready_o, wb_we_o});
        end
        @(negedge clk_i);
        rst_i = 1'b1;
        bus_rvalid_i = 1'b1; bus_rdata_i = $urandom;
        for (int i = 0; i < 3; i++) begin
            step();
            bus_rvalid_i = 1'b0;
            n_vec++;
            if ({wb_we_o, busy_o, bus_err_o, bus_req_o} !== 4'b0000) begin
                n_err++;
                $display("FAIL reset_abandon[%0d]: got %b expected 0000", i, {wb_we_o, busy_o, bus_err_o, bus_req_o});
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random(300);
        test_back_to_back();
        test_timeout_req();
        test_timeout_wait(1'b0);
        test_timeout_wait(1'b1);
        test_reset_mid(1'b0);
        test_reset_mid(1'b1);
        test_random(50);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_unit.md
LSU_UNIT -- requirements
Module: lsu_unit

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of cycles from REQ entry to response before abort.
REQ-002 The block SHALL have port clk_i, input, 1 bit: clock, rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port req_valid_i, input, 1 bit: EX-stage memory request valid.
REQ-005 The block SHALL have port req_ready_o, output, 1 bit: request accepted this cycle when high together with req_valid_i.
REQ-006 The block SHALL have port req_we_i, input, 1 bit: 1 = store, 0 = load.
REQ-007 The block SHALL have port req_funct3_i, input, 3 bits: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 The block SHALL have port req_addr_i, input, 32 bits: byte address.
REQ-009 The block SHALL have port req_wdata_i, input, 32 bits: store data (rs2).
REQ-010 The block SHALL have port req_rd_i, input, 5 bits: load destination register.
REQ-011 The block SHALL have ports bus_req_o (output, 1), bus_we_o (output, 1), bus_addr_o (output, 32, word-aligned), bus_wdata_o (output, 32) and bus_be_o (output, 4) for the data bus request.
REQ-012 The block SHALL have ports bus_gnt_i (input, 1), bus_rvalid_i (input, 1) and bus_rdata_i (input, 32) for the data bus grant and response.
REQ-013 The block SHALL have ports wb_we_o (output, 1), wb_rd_o (output, 5) and wb_data_o (output, 32) as the register-file write port (RegWEn, AddrD, DataD).
REQ-014 The block SHALL have ports busy_o (output, 1), misalign_o (output, 1, pulse) and bus_err_o (output, 1, pulse).

Function
REQ-015 The FSM SHALL have states IDLE, REQ, WAIT and WB, and SHALL set busy_o = 1 in every state other than IDLE.
REQ-016 In IDLE, req_ready_o SHALL be 1, and in every other state it SHALL be 0.
REQ-017 On accept, the block SHALL latch we, funct3, addr, wdata and rd.
REQ-018 An accepted request SHALL be treated as misaligned when it is H/HU with addr[0]=1, or W with addr[1:0]!=0, or any reserved funct3 (loads 011/110/111, stores other than 000/001/010).
REQ-019 A misaligned request SHALL pulse misalign_o for exactly one cycle (the cycle after accept), SHALL stay in IDLE and SHALL cause no bus activity.
REQ-020 An aligned accepted request SHALL move the FSM to REQ.
REQ-021 In REQ, bus_req_o SHALL be 1, and addr, we, be and wdata SHALL stay stable until bus_gnt_i=1; on grant the FSM SHALL go to WAIT.
REQ-022 bus_addr_o SHALL equal {addr[31:2], 2'b00}.
REQ-023 bus_be_o SHALL be 0001 shifted left by addr[1:0] for B, 0011 or 1100 per addr[1] for H, and 1111 for W.
REQ-024 bus_wdata_o SHALL be {4{wdata[7:0]}} for SB, {2{wdata[15:0]}} for SH and wdata for SW.
REQ-025 bus_rvalid_i SHALL be honoured only in WAIT and ignored in all other states.
REQ-026 In WAIT, when bus_rvalid_i=1, a load SHALL register the formatted data and go to WB, and a store SHALL return to IDLE with no writeback.
REQ-027 Load formatting SHALL select the byte or halfword lane by addr[1:0]; B/H SHALL sign-extend, BU/HU SHALL zero-extend, and W SHALL pass data unchanged.
REQ-028 In WB, the block SHALL drive wb_rd_o = rd and wb_data_o = formatted data for exactly one cycle, with wb_we_o = 1 only if rd != 0, then return to IDLE.
REQ-029 Outside WB, wb_we_o SHALL be 0.
REQ-030 The timeout counter SHALL clear on REQ entry and increment each cycle in REQ and WAIT.
REQ-031 When the timeout counter reaches TIMEOUT_CYCLES, the block SHALL pulse bus_err_o for one cycle, drop bus_req_o, return to IDLE and perform no writeback.
REQ-032 When bus_rvalid_i=1 in the same cycle that the timeout is reached, the response SHALL win.
REQ-033 Minimum load latency SHALL be: accept at cycle 0, REQ+gnt at cycle 1, rvalid at cycle 2, wb_we_o=1 at cycle 3.
REQ-034 A new request SHALL NOT be accepted in the WB cycle; the next accept SHALL occur no earlier than the following IDLE cycle.

Reset
REQ-035 While rst_i=0, the FSM SHALL be in IDLE, the counter and all latched fields SHALL be 0, and all outputs SHALL be 0 except req_ready_o=1.
REQ-036 Reset asserted mid-transaction SHALL abandon the transaction, SHALL produce no writeback and no error pulse, and SHALL drop bus_req_o immediately (asynchronously).

Verification
REQ-037 LB addr=0x1003, rdata=0x80FF_0000, gnt at cycle 1, rvalid at cycle 2, rd=5 -> cycle 3: wb_we_o=1, wb_rd_o=5, wb_data_o=0xFFFF_FF80.
REQ-038 SH addr=0x2002, wdata=0x0000_BEEF -> bus_addr_o=0x2000, bus_be_o=1100, bus_wdata_o=0xBEEF_BEEF, bus_we_o=1, and no writeback after rvalid.
REQ-039 LW addr=0x3001 -> misalign_o pulses once, bus_req_o stays 0, req_ready_o=1 the next cycle.
REQ-040 LHU addr=0x4002, rd=0, rdata=0x9234_0000 -> WB cycle has wb_we_o=0 and wb_data_o=0x0000_9234.
REQ-041 Load with bus_gnt_i held 0 for TIMEOUT_CYCLES cycles -> bus_err_o pulses once, the FSM returns to IDLE and wb_we_o stays 0.
REQ-042 rst_i driven low during WAIT, then rvalid after release -> no writeback and busy_o=0.
